// File: rtl/mm_score_sequencer.sv
// rtl/mm_score_sequencer.sv - Mastermind guess scoring and turn/win/lose controller
// Optional SCORE_EARLY_EXIT_EN: skip the colour scan when the exact scan already found 4 blacks.
module mm_score_sequencer #(
    parameter int COLOR_W   = 3,
    parameter int MAX_TURNS = 10,
    parameter int TURN_W    = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 new_game,
    input  logic [4*COLOR_W-1:0] code_flat,
    input  logic [4*COLOR_W-1:0] guess_flat,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           black,
    output logic [2:0]           white,
    output logic                 win,
    output logic                 lose,
    output logic [TURN_W-1:0]    turn_count
);
    localparam int PEG_W = 4 * COLOR_W;

    typedef enum logic [2:0] {S_IDLE, S_EXACT, S_COLOR, S_FINISH, S_OVER} state_t;

    state_t             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [PEG_W-1:0]   code_q, code_d, guess_q, guess_d;
    logic [3:0]         code_used_q, code_used_d, guess_used_q, guess_used_d;
    logic [2:0]         bacc_q, bacc_d, wacc_q, wacc_d;
    logic [2:0]         black_q, black_d, white_q, white_d;
    logic               win_q, win_d, lose_q, lose_d, done_q, done_d, busy_q, busy_d;
    logic [TURN_W-1:0]  turn_q, turn_d, turn_inc;

    function automatic logic [COLOR_W-1:0] peg(input logic [PEG_W-1:0] f, input logic [1:0] k);
        return f[int'(k)*COLOR_W +: COLOR_W];
    endfunction

    assign turn_inc = (turn_q == '1) ? turn_q : turn_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        code_d       = code_q;
        guess_d      = guess_q;
        code_used_d  = code_used_q;
        guess_used_d = guess_used_q;
        bacc_d       = bacc_q;
        wacc_d       = wacc_q;
        black_d      = black_q;
        white_d      = white_q;
        win_d        = win_q;
        lose_d       = lose_q;
        turn_d       = turn_q;
        done_d       = 1'b0;

        if (new_game) begin
            state_d      = S_IDLE;
            idx_d        = '0;
            code_used_d  = '0;
            guess_used_d = '0;
            bacc_d       = '0;
            wacc_d       = '0;
            black_d      = '0;
            white_d      = '0;
            win_d        = 1'b0;
            lose_d       = 1'b0;
            turn_d       = '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    code_d       = code_flat;
                    guess_d      = guess_flat;
                    code_used_d  = '0;
                    guess_used_d = '0;
                    bacc_d       = '0;
                    wacc_d       = '0;
                    idx_d        = '0;
                    state_d      = S_EXACT;
                end
                S_EXACT: begin
                    if (peg(code_q, idx_q[1:0]) == peg(guess_q, idx_q[1:0])) begin
                        bacc_d                   = bacc_q + 3'd1;
                        code_used_d[idx_q[1:0]]  = 1'b1;
                        guess_used_d[idx_q[1:0]] = 1'b1;
                    end
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd3) begin
                        idx_d   = '0;
                        state_d = S_COLOR;
`ifdef SCORE_EARLY_EXIT_EN
                        if (bacc_d == 3'd4) state_d = S_FINISH;
`endif
                    end
                end
                S_COLOR: begin
                    // idx[3:2] walks guess pegs, idx[1:0] walks code pegs; flags stop double counting
                    if (!guess_used_q[idx_q[3:2]] && !code_used_q[idx_q[1:0]] &&
                        peg(guess_q, idx_q[3:2]) == peg(code_q, idx_q[1:0])) begin
                        wacc_d                   = wacc_q + 3'd1;
                        guess_used_d[idx_q[3:2]] = 1'b1;
                        code_used_d[idx_q[1:0]]  = 1'b1;
                    end
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) state_d = S_FINISH;
                end
                S_FINISH: begin
                    done_d  = 1'b1;
                    black_d = bacc_q;
                    white_d = wacc_q;
                    turn_d  = turn_inc;
                    win_d   = (bacc_q == 3'd4);
                    lose_d  = !win_d && (turn_inc == TURN_W'(MAX_TURNS));
                    state_d = (win_d || lose_d) ? S_OVER : S_IDLE;
                end
                default: state_d = S_OVER;
            endcase
        end
        busy_d = (state_d == S_EXACT) || (state_d == S_COLOR) || (state_d == S_FINISH);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            code_q       <= '0;
            guess_q      <= '0;
            code_used_q  <= '0;
            guess_used_q <= '0;
            bacc_q       <= '0;
            wacc_q       <= '0;
            black_q      <= '0;
            white_q      <= '0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            turn_q       <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            code_q       <= code_d;
            guess_q      <= guess_d;
            code_used_q  <= code_used_d;
            guess_used_q <= guess_used_d;
            bacc_q       <= bacc_d;
            wacc_q       <= wacc_d;
            black_q      <= black_d;
            white_q      <= white_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
            turn_q       <= turn_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign black      = black_q;
    assign white      = white_q;
    assign win        = win_q;
    assign lose       = lose_q;
    assign turn_count = turn_q;
endmodule

// File: tb/tb_mm_score_sequencer.sv
// tb/tb_mm_score_sequencer.sv - scoreboard bench for mm_score_sequencer
module tb_mm_score_sequencer;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        new_game = 1'b0;
    logic [11:0] code_flat = '0;
    logic [11:0] guess_flat = '0;
    logic        busy, done, win, lose;
    logic [2:0]  black, white;
    logic [3:0]  turn_count;

`ifdef SCORE_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        int black;
        int white;
        int win;
        int lose;
        int turn;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    mm_score_sequencer #(.COLOR_W(3), .MAX_TURNS(10), .TURN_W(4)) dut (
        .clk(clk), .resetn(resetn), .start(start), .new_game(new_game),
        .code_flat(code_flat), .guess_flat(guess_flat),
        .busy(busy), .done(done), .black(black), .white(white),
        .win(win), .lose(lose), .turn_count(turn_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [11:0] pk(input logic [2:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("black", int'(black), e.black);
                chk("white", int'(white), e.white);
                chk("win", int'(win), e.win);
                chk("lose", int'(lose), e.lose);
                chk("turn_count", int'(turn_count), e.turn);
                chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [11:0] c, g, input int b, w, wn, ls, tn);
        exp_t e;
        @(negedge clk);
        code_flat = c; guess_flat = g; start = 1'b1;
        e.black = b; e.white = w; e.win = wn; e.lose = ls; e.turn = tn;
        e.cyc = cyc + 1 + ((wn != 0 && EARLY) ? 5 : 21);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic do_new_game();
        @(negedge clk); new_game = 1'b1;
        @(negedge clk); new_game = 1'b0;
    endtask

    task automatic ignored_start(input string name);
        int busy_seen = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (busy) busy_seen = 1;
        end
        chk(name, busy_seen, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_black", int'(black), 0);
        chk("rst_white", int'(white), 0);
        chk("rst_win_lose", int'({win, lose}), 0);
        chk("rst_turn", int'(turn_count), 0);
        resetn = 1'b1;

        // Winning guess, then OVER ignores start
        issue(pk(1, 2, 3, 4), pk(1, 2, 3, 4), 4, 0, 1, 0, 1);
        drain();
        ignored_start("over_busy");
        chk("over_win_hold", int'(win), 1);

        do_new_game();
        chk("ng_turn", int'(turn_count), 0);
        chk("ng_win", int'(win), 0);
        chk("ng_black", int'(black), 0);

        issue(pk(1, 1, 2, 2), pk(2, 2, 1, 1), 0, 4, 0, 0, 1);
        drain();
        issue(pk(1, 2, 3, 4), pk(1, 1, 1, 1), 1, 0, 0, 0, 2);
        drain();
        issue(pk(1, 1, 2, 3), pk(3, 1, 1, 5), 1, 2, 0, 0, 3);
        drain();

        // Lose after MAX_TURNS
        do_new_game();
        for (int k = 1; k <= 10; k++) begin
            issue(pk(0, 0, 0, 0), pk(7, 7, 7, 7), 0, 0, 0, (k == 10) ? 1 : 0, k);
            drain();
        end
        ignored_start("eleventh_busy");
        chk("lose_hold", int'(lose), 1);
        chk("turn_hold", int'(turn_count), 10);

        // Restart pulses and guess changes during the scan must not disturb the snapshot
        do_new_game();
        issue(pk(1, 2, 3, 4), pk(4, 3, 2, 1), 0, 4, 0, 0, 1);
        chk("scan_busy", int'(busy), 1);
        start = 1'b1; guess_flat = pk(1, 2, 3, 4);
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1; guess_flat = pk(1, 1, 1, 1);
        @(negedge clk); start = 1'b0;
        drain();
        repeat (25) @(negedge clk);

        // new_game with start during COLOR aborts the turn
        @(negedge clk);
        code_flat = pk(1, 2, 3, 4); guess_flat = pk(1, 2, 4, 3); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        new_game = 1'b1; start = 1'b1;
        @(negedge clk); new_game = 1'b0; start = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_white", int'(white), 0);
        chk("abort_turn", int'(turn_count), 0);
        repeat (30) @(negedge clk);

        // Reset during EXACT aborts the turn
        issue(pk(1, 2, 3, 4), pk(1, 2, 4, 3), 2, 2, 0, 0, 1);
        drain();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); resetn = 1'b0;
        @(negedge clk); resetn = 1'b1;
        chk("rstx_busy", int'(busy), 0);
        chk("rstx_black", int'(black), 0);
        chk("rstx_turn", int'(turn_count), 0);
        repeat (30) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
